// File: rtl/vga_pkg.sv
// Shared VGA timing constants, colour type and test-pattern colour table.
// Optional test-pattern generator in vga_ctrl is enabled by defining VGA_TESTPAT_EN.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    typedef logic [11:0] rgb12;

    localparam int BAR_COUNT = 8;

    // Colour bars, left to right: white, yellow, cyan, green, magenta, red, blue, black
    localparam rgb12 TESTPAT_COLOURS [BAR_COUNT] = '{
        12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
        12'hF0F, 12'hF00, 12'h00F, 12'h000
    };

    function automatic rgb12 bar_colour(input logic [2:0] idx);
        return TESTPAT_COLOURS[idx];
    endfunction

endpackage

// File: rtl/vga_tick_gen.sv
// Pixel-rate prescaler: asserts tick for one clk out of every DIV.
module vga_tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    logic [DW-1:0] div;

    always_ff @(posedge clk) begin
        if (rst) begin
            div <= '0;
        end else if (tick) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    assign tick = (div == DIV_LAST);

endmodule

// File: rtl/vga_ctrl.sv
// VGA timing generator with one-pixel colour/sync pipeline.
// Define VGA_TESTPAT_EN to add the test_en port and the built-in colour-bar pattern.
module vga_ctrl
    import vga_pkg::*;
#(
    parameter int DIV      = 4,
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FP     = vga_pkg::H_FP,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FP     = vga_pkg::V_FP,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BP     = vga_pkg::V_BP
) (
`ifdef VGA_TESTPAT_EN
    input  logic        test_en,
`endif
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] data,
    output logic [9:0]  x,
    output logic [8:0]  y,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        hs,
    output logic        vs,
    output logic        frame_start
);

    localparam int H_LEN    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_LEN    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_FIRST = H_ACTIVE + H_FP;
    localparam int HS_LAST  = H_ACTIVE + H_FP + H_SYNC - 1;
    localparam int VS_FIRST = V_ACTIVE + V_FP;
    localparam int VS_LAST  = V_ACTIVE + V_FP + V_SYNC - 1;
    localparam int BAR_W    = H_ACTIVE / BAR_COUNT;

    logic       tick;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       h_last;
    logic       v_last;
    logic       h_vis;
    logic       v_vis;
    logic       active;
    logic       in_hsync;
    logic       in_vsync;
    rgb12       pixel;
    rgb12       rgb;

    vga_tick_gen #(.DIV(DIV)) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    always_comb begin
        h_last   = (h_cnt == 10'(H_LEN - 1));
        v_last   = (v_cnt == 10'(V_LEN - 1));
        h_vis    = (h_cnt < 10'(H_ACTIVE));
        v_vis    = (v_cnt < 10'(V_ACTIVE));
        active   = h_vis && v_vis;
        in_hsync = (h_cnt >= 10'(HS_FIRST)) && (h_cnt <= 10'(HS_LAST));
        in_vsync = (v_cnt >= 10'(VS_FIRST)) && (v_cnt <= 10'(VS_LAST));
`ifdef VGA_TESTPAT_EN
        pixel = test_en ? bar_colour(3'(h_cnt / 10'(BAR_W))) : data;
`else
        pixel = data;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (tick) begin
            if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? 10'd0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    // Colour and sync are registered from the pre-increment counters so they stay aligned, one pixel behind x,y
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb         <= '0;
            hs          <= 1'b1;
            vs          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            frame_start <= tick && h_last && v_last;
            if (tick) begin
                rgb <= active ? pixel : 12'h000;
                hs  <= !in_hsync;
                vs  <= !in_vsync;
            end
        end
    end

    assign x     = h_vis ? h_cnt : 10'd0;
    assign y     = v_vis ? v_cnt[8:0] : 9'd0;
    assign vga_r = rgb[11:8];
    assign vga_g = rgb[7:4];
    assign vga_b = rgb[3:0];

endmodule

// File: tb/tb_vga_ctrl.sv
// Self-checking bench for vga_ctrl using a reduced frame height so full frames fit in a short run.
// Pixel-index arithmetic model; optional VGA_TESTPAT_EN section exercises the colour bars.
module tb_vga_ctrl;

    localparam int DIV        = 2;
    localparam int HA         = 640;
    localparam int HFP        = 16;
    localparam int HSW        = 96;
    localparam int HBP        = 48;
    localparam int VA         = 8;
    localparam int VFP        = 2;
    localparam int VSW        = 2;
    localparam int VBP        = 2;
    localparam int HT         = HA + HFP + HSW + HBP;
    localparam int VT         = VA + VFP + VSW + VBP;
    localparam int FRAME_CLKS = HT * VT * DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] data = 12'h000;
    logic [9:0]  x;
    logic [8:0]  y;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;
    logic        hs;
    logic        vs;
    logic        frame_start;
`ifdef VGA_TESTPAT_EN
    logic        test_en = 1'b0;
`endif

    always #5 clk = ~clk;

    vga_ctrl #(
        .DIV(DIV), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP)
    ) dut (
`ifdef VGA_TESTPAT_EN
        .test_en     (test_en),
`endif
        .clk         (clk),
        .rst         (rst),
        .data        (data),
        .x           (x),
        .y           (y),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .hs          (hs),
        .vs          (vs),
        .frame_start (frame_start)
    );

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input bit ten, input int cycles);
        @(posedge clk);
        #1;
        rst = r;
`ifdef VGA_TESTPAT_EN
        test_en = ten;
`else
        if (ten) $display("[TB] test pattern not built, test_en ignored");
`endif
        repeat (cycles) @(posedge clk);
    endtask

    // Model state: e = clk edges since reset release, pixel index = e / DIV
    int   e        = 0;
    int   epoch    = 0;
    int   m_n      = 0;
    int   m_h      = 0;
    int   m_v      = 0;
    int   exp_rgb  = 0;
    int   exp_hs   = 1;
    int   exp_vs   = 1;
    int   exp_fs   = 0;
    logic prev_rst = 1'b1;
    logic prev_ten = 1'b0;
    int   bars [8] = '{'hFFF, 'hFF0, 'h0FF, 'h0F0, 'hF0F, 'hF00, 'h00F, 'h000};

    int   fs_count0  = 0;
    int   vs_low0    = 0;
    int   hs_fall_e  = -1;
    int   hs_low_len = 0;
    int   hs_period  = 0;
    logic last_hs    = 1'b1;

    always @(negedge clk) begin
        int q;
        int qh;
        int qv;
        int act_rgb;
        if (prev_rst) begin
            if (e > 0) epoch++;
            e       = 0;
            exp_rgb = 0;
            exp_hs  = 1;
            exp_vs  = 1;
        end else begin
            e++;
        end
        m_n    = e / DIV;
        m_h    = m_n % HT;
        m_v    = (m_n / HT) % VT;
        exp_fs = 0;
        act_rgb = int'({vga_r, vga_g, vga_b});

        if (!prev_rst && (e % DIV == 0) && m_n > 0) begin
            q  = m_n - 1;
            qh = q % HT;
            qv = (q / HT) % VT;
            if (qh < HA && qv < VA) exp_rgb = prev_ten ? bars[qh / (HA / 8)] : int'(data);
            else                    exp_rgb = 0;
            exp_hs = (qh >= HA + HFP && qh <= HA + HFP + HSW - 1) ? 0 : 1;
            exp_vs = (qv >= VA + VFP && qv <= VA + VFP + VSW - 1) ? 0 : 1;
            exp_fs = (m_n % (HT * VT) == 0) ? 1 : 0;

            if (epoch == 0 && q < HT * VT) begin
                if (qh == 5 && qv == 7)        checkOutput("pin_rgb_5_7", act_rgb, 'h57A);
                if (qh == HA - 1 && qv == VA - 1) checkOutput("pin_rgb_639_last", act_rgb, 'hFFF);
                if (qh == HA && qv == VA - 1)     checkOutput("pin_rgb_640_last", act_rgb, 'h000);
                if (qv == 0) begin
                    case (qh)
                        655: checkOutput("pin_hs_655", int'(hs), 1);
                        656: checkOutput("pin_hs_656", int'(hs), 0);
                        751: checkOutput("pin_hs_751", int'(hs), 0);
                        752: checkOutput("pin_hs_752", int'(hs), 1);
                        700: checkOutput("pin_rgb_blank_700", act_rgb, 0);
                        default: ;
                    endcase
                end
            end
`ifdef VGA_TESTPAT_EN
            if (epoch == 1 && prev_ten && qv < VA) begin
                if (qh == 0)   checkOutput("pin_bar_x0", act_rgb, 'hFFF);
                if (qh == 79)  checkOutput("pin_bar_x79", act_rgb, 'hFFF);
                if (qh == 400) checkOutput("pin_bar_x400", act_rgb, 'hF00);
                if (qh == 479) checkOutput("pin_bar_x479", act_rgb, 'hF00);
                if (qh == 560) checkOutput("pin_bar_x560", act_rgb, 'h000);
                if (qh == 639) checkOutput("pin_bar_x639", act_rgb, 'h000);
            end
`endif
        end

        checkOutput("x", int'(x), (m_h < HA && !prev_rst) ? m_h : 0);
        checkOutput("y", int'(y), (m_v < VA && !prev_rst) ? m_v : 0);
        checkOutput("rgb", act_rgb, exp_rgb);
        checkOutput("hs", int'(hs), exp_hs);
        checkOutput("vs", int'(vs), exp_vs);
        checkOutput("frame_start", int'(frame_start), exp_fs);

        if (epoch == 0 && !prev_rst) begin
            if (e <= FRAME_CLKS) begin
                fs_count0 += int'(frame_start);
                vs_low0   += int'(!vs);
            end
            if (last_hs && !hs) begin
                if (hs_fall_e >= 0 && hs_period == 0) hs_period = e - hs_fall_e;
                hs_fall_e = e;
            end
            if (!last_hs && hs && hs_fall_e >= 0 && hs_low_len == 0) hs_low_len = e - hs_fall_e;
        end
        last_hs = hs;

        if (epoch == 1 && prev_ten)                 data = 12'h123;
        else if (m_v == VA - 1 && m_h >= 600)       data = 12'hFFF;
        else if (m_v % 2 == 1)                      data = {4'(m_h), 4'(m_v), 4'hA};
        else                                        data = 12'($urandom);

        prev_rst = rst;
`ifdef VGA_TESTPAT_EN
        prev_ten = test_en;
`endif
    end

    initial begin
        int k;
        $display("[TB] starting vga_ctrl bench");
        applyStimulus(1'b1, 1'b0, 3);
        applyStimulus(1'b0, 1'b0, 0);

        k = 0;
        while (m_n < HT * VT + 5 * HT + 700 && k < 2 * FRAME_CLKS) begin
            @(negedge clk);
            #1;
            k++;
        end
        checkOutput("reach_mid_frame", (k < 2 * FRAME_CLKS) ? 1 : 0, 1);

        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst_x", int'(x), 0);
        checkOutput("rst_hs", int'(hs), 1);
        checkOutput("rst_vs", int'(vs), 1);
        checkOutput("rst_rgb", int'({vga_r, vga_g, vga_b}), 0);
        rst = 1'b0;

        k = 0;
        while (x != 10'd1 && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        checkOutput("first_tick_clks", k, DIV);

`ifdef VGA_TESTPAT_EN
        applyStimulus(1'b0, 1'b1, 2 * HT * DIV);
        applyStimulus(1'b0, 1'b0, 4);
`else
        applyStimulus(1'b0, 1'b0, 2 * HT * DIV);
`endif

        checkOutput("frame_start_count", fs_count0, 1);
        checkOutput("hs_low_clks", hs_low_len, HSW * DIV);
        checkOutput("hs_period_clks", hs_period, HT * DIV);
        checkOutput("vs_low_clks", vs_low0, VSW * HT * DIV);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_ctrl.md
VGA_CTRL -- requirements
Module: vga_ctrl

Interface
REQ-001 Parameter DIV, default 4: clk cycles per pixel; 100 MHz clk gives a 25 MHz pixel rate.
REQ-002 Parameter H_ACTIVE/H_FP/H_SYNC/H_BP, defaults 640/16/96/48: horizontal timing in pixels; H_TOTAL = 800.
REQ-003 Parameter V_ACTIVE/V_FP/V_SYNC/V_BP, defaults 480/10/2/33: vertical timing in lines; V_TOTAL = 525.
REQ-004 Port clk, input, 1: single system clock, 100 MHz; all logic on its rising edge.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Port data, input, 12: pixel colour {R[11:8],G[7:4],B[3:0]} returned by display modules for the current x,y.
REQ-007 Port x, output, 10: active-area column, 0..639.
REQ-008 Port y, output, 9: active-area row, 0..479.
REQ-009 Port vga_r/vga_g/vga_b, output, 4 each: colour to DAC.
REQ-010 Port hs/vs, output, 1 each: horizontal/vertical sync, active low.
REQ-011 Port frame_start, output, 1: one-clk pulse at frame wrap.

Function
REQ-012 Prescaler div counts 0..DIV-1 and wraps; tick is asserted for the one clk cycle where div==DIV-1.
REQ-013 h_cnt (10 bit) counts 0..H_TOTAL-1 on tick and wraps to 0; v_cnt (10 bit) increments on the tick where h_cnt wraps, counts 0..V_TOTAL-1, and wraps to 0.
REQ-014 Active is h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
REQ-015 x = h_cnt when h_cnt<H_ACTIVE, else 0; y = v_cnt[8:0] when v_cnt<V_ACTIVE, else 0; both come from registers only, with no path from data.
REQ-016 x,y stay stable for all DIV clks of a pixel period, which gives display ROMs at least DIV-1 clks of read latency.
REQ-017 On tick, register rgb <= active ? data : 12'h000, using the counter values before the increment.
REQ-018 On the same tick, register hs <= !(h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]) and vs <= !(v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]).
REQ-019 Latency: colour and sync for coordinate (h,v) are driven during the pixel period after the one in which x,y=(h,v) were presented; colour and sync stay mutually aligned.
REQ-020 frame_start is high for exactly one clk, on the tick where h_cnt==H_TOTAL-1 and v_cnt==V_TOTAL-1.
REQ-021 Outputs change only on tick cycles, except frame_start, which falls on the cycle after its tick.

Reset
REQ-022 While rst=1: div, h_cnt, v_cnt = 0; x=0, y=0; vga_r/g/b=0; hs=1, vs=1; frame_start=0.
REQ-023 Reset asserted mid-line or mid-frame takes effect on the next clk edge, with no partial sync pulse stretched.
REQ-024 After rst deasserts, the first tick occurs DIV clks later and the frame restarts at (0,0).

Configuration
REQ-025 Macro VGA_TESTPAT_EN.
- Defined: adds input port test_en (1 bit). When test_en=1, active pixels show 8 vertical bars of 80 px, bar index = x/80, colours {FFF,FF0,0FF,0F0,F0F,F00,00F,000}, and data is ignored. Blanking is still 0.
- Undefined: port test_en is absent and REQ-017 applies unconditionally.

Structure
REQ-026 Package vga_pkg holds the timing constants (H_*/V_*, H_TOTAL, V_TOTAL), the test-pattern colour table and the rgb12 typedef.
REQ-027 Sub-module vga_tick_gen holds the DIV prescaler and outputs tick; counters, sync and the colour pipeline stay in vga_ctrl.

Verification
REQ-028 Run rst then 4*800*525 clks -> exactly one frame_start pulse; hs period 3200 clks and low 384 clks; vs low 2 lines = 6400 clks.
REQ-029 Drive data = {x[3:0], y[3:0], 4'hA} -> at (x=5,y=7), rgb = 0x57A one pixel period after x=5,y=7 is presented; all rgb=0 in blanking.
REQ-030 Sample h_cnt=655, 656, 751, 752 on line 0 -> hs goes low on the pixel after h_cnt=656 and high on the pixel after h_cnt=752; x=0 throughout blanking.
REQ-031 Assert rst for 1 clk at h_cnt=700, v_cnt=300 -> next cycle all counters are 0, hs=vs=1, rgb=0; first tick after 4 clks.
REQ-032 With VGA_TESTPAT_EN and test_en=1, data=0x123 -> x=0..79 gives FFF, x=400..479 gives F00, x=560..639 gives 000.
REQ-033 With data=0xFFF constant, check the last active pixel (639,479) -> rgb 0xFFF; next pixel (640,479) -> rgb 0x000.
